// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: shared FSM states and AXI constants for the memory responder
package axi_mem_pkg;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 32;
    localparam logic [2:0] AXI_SIZE_64 = 3'd3;
    localparam logic [1:0] AXI_BURST_INCR = 2'd1;
    typedef enum logic [2:0] {IDLE, AW_WAIT, WDATA, BRESP, AR_WAIT, RDATA} state_t;
endpackage

// File: rtl/axi_mem_responder_if.sv
// axi_mem_responder_if: AXI4 write/read channel bundle (no BRESP/RRESP, always OKAY)
interface axi_mem_responder_if;
    import axi_mem_pkg::*;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0] awlen;
    logic [2:0] awsize;
    logic [1:0] awburst;
    logic [2:0] awprot;
    logic awvalid;
    logic awready;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic wlast;
    logic wvalid;
    logic wready;
    logic bvalid;
    logic bready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst;
    logic [2:0] arprot;
    logic arvalid;
    logic arready;
    logic [DATA_W-1:0] rdata;
    logic rlast;
    logic rvalid;
    logic rready;
    modport master (
        output awaddr, awlen, awsize, awburst, awprot, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output araddr, arlen, arsize, arburst, arprot, arvalid, rready,
        input awready, wready, bvalid, arready, rdata, rlast, rvalid
    );
    modport slave (
        input awaddr, awlen, awsize, awburst, awprot, awvalid,
        input wdata, wstrb, wlast, wvalid, bready,
        input araddr, arlen, arsize, arburst, arprot, arvalid, rready,
        output awready, wready, bvalid, arready, rdata, rlast, rvalid
    );
endinterface

// File: rtl/axi_mem_ram.sv
// axi_mem_ram: single-port 64-bit RAM with byte enables and registered read data
module axi_mem_ram #(
    parameter int MEM_WORDS_LOG2 = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic [7:0] i_we,
    input  logic i_re,
    input  logic [MEM_WORDS_LOG2-1:0] i_addr,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_rdata
);
    logic [63:0] r_mem [1<<MEM_WORDS_LOG2];
    logic [63:0] r_rdata;
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 8; b++)
            if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    // Output register only loads on a read, so data holds while the master stalls
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_addr];
    end
    assign o_rdata = r_rdata;
endmodule

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave backed by a word-addressed RAM, one transaction at a time,
// writes win over reads when both address channels are valid together.
module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int MEM_WORDS_LOG2 = 10,
    parameter int READY_DELAY = 0
) (
    input  logic S_AXI_ACLK,
    input  logic S_AXI_ARESETN,
    axi_mem_responder_if.slave s_axi,
    output logic proto_err
);
    localparam int AW = MEM_WORDS_LOG2;
    state_t r_state;
    logic [3:0] r_dly;
    logic [AW-1:0] r_idx;
    logic [7:0] r_cnt;
    logic r_awready, r_wready, r_bvalid, r_arready, r_rvalid, r_rlast, r_err;
    logic w_w_hs, w_ar_hs, w_r_hs, w_re, w_dly_done;
    logic [AW-1:0] w_ar_idx, w_addr;
    logic [7:0] w_we;
    logic [DATA_W-1:0] w_rdata;
    logic w_unused;
    assign w_w_hs = r_wready && s_axi.wvalid;
    assign w_ar_hs = r_arready && s_axi.arvalid;
    assign w_r_hs = r_rvalid && s_axi.rready;
    assign w_ar_idx = s_axi.araddr[AW+2:3];
    // The AR handshake reads the first word straight from the address bus so RVALID follows in one cycle
    assign w_re = w_ar_hs || (w_r_hs && r_cnt != 8'd0);
    assign w_addr = w_ar_hs ? w_ar_idx : r_idx;
    assign w_we = {8{w_w_hs}} & s_axi.wstrb;
    assign w_dly_done = r_dly == 4'(READY_DELAY - 1);
    assign w_unused = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[2:0], s_axi.araddr[2:0],
                        s_axi.awaddr[ADDR_W-1:AW+3], s_axi.araddr[ADDR_W-1:AW+3]};
    axi_mem_ram #(.MEM_WORDS_LOG2(AW)) u_ram (
        .i_clk(S_AXI_ACLK),
        .i_rst_n(S_AXI_ARESETN),
        .i_we(w_we),
        .i_re(w_re),
        .i_addr(w_addr),
        .i_wdata(s_axi.wdata),
        .o_rdata(w_rdata)
    );
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= IDLE;
            r_dly <= '0;
            r_idx <= '0;
            r_cnt <= '0;
            r_awready <= 1'b0;
            r_wready <= 1'b0;
            r_bvalid <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid <= 1'b0;
            r_rlast <= 1'b0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_dly <= '0;
                    if (s_axi.awvalid) begin
                        r_state <= AW_WAIT;
                        r_awready <= READY_DELAY == 0;
                    end else if (s_axi.arvalid) begin
                        r_state <= AR_WAIT;
                        r_arready <= READY_DELAY == 0;
                    end
                end
                AW_WAIT: begin
                    if (!r_awready) begin
                        r_dly <= r_dly + 4'd1;
                        r_awready <= w_dly_done;
                    end else if (s_axi.awvalid) begin
                        r_awready <= 1'b0;
                        r_idx <= s_axi.awaddr[AW+2:3];
                        r_cnt <= s_axi.awlen;
                        r_dly <= '0;
                        r_wready <= READY_DELAY == 0;
                        if (s_axi.awsize != AXI_SIZE_64 || s_axi.awburst != AXI_BURST_INCR) r_err <= 1'b1;
                        r_state <= WDATA;
                    end
                end
                WDATA: begin
                    if (!r_wready) begin
                        r_dly <= r_dly + 4'd1;
                        r_wready <= w_dly_done;
                    end else if (s_axi.wvalid) begin
                        if (s_axi.wlast != (r_cnt == 8'd0)) r_err <= 1'b1;
                        r_idx <= r_idx + AW'(1);
                        r_cnt <= r_cnt - 8'd1;
                        if (r_cnt == 8'd0) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_state <= BRESP;
                        end
                    end
                end
                BRESP: begin
                    if (s_axi.bready) begin
                        r_bvalid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                AR_WAIT: begin
                    if (!r_arready) begin
                        r_dly <= r_dly + 4'd1;
                        r_arready <= w_dly_done;
                    end else if (s_axi.arvalid) begin
                        r_arready <= 1'b0;
                        r_idx <= w_ar_idx + AW'(1);
                        r_cnt <= s_axi.arlen;
                        r_rvalid <= 1'b1;
                        r_rlast <= s_axi.arlen == 8'd0;
                        if (s_axi.arsize != AXI_SIZE_64 || s_axi.arburst != AXI_BURST_INCR) r_err <= 1'b1;
                        r_state <= RDATA;
                    end
                end
                RDATA: begin
                    if (s_axi.rready) begin
                        if (r_cnt == 8'd0) begin
                            r_rvalid <= 1'b0;
                            r_rlast <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx + AW'(1);
                            r_cnt <= r_cnt - 8'd1;
                            r_rlast <= r_cnt == 8'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign s_axi.awready = r_awready;
    assign s_axi.wready = r_wready;
    assign s_axi.bvalid = r_bvalid;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid = r_rvalid;
    assign s_axi.rlast = r_rlast;
    assign s_axi.rdata = w_rdata;
    assign proto_err = r_err;
endmodule
